// File: rtl/snake_cmd_pkg.sv
// Shared constants and types for the snake command executor: opcodes,
// command word field positions/widths and the sequencer state encoding.
package snake_cmd_pkg;

    localparam int CMD_WIDTH = 32;

    // Opcode occupies the top nibble of every command word.
    localparam int OP_LSB = 28;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_RECT = 4'h1;
    localparam logic [OP_W-1:0] OP_LINE = 4'h9;
    localparam logic [OP_W-1:0] OP_CHAR = 4'ha;

    // RECT word: corners in logic cells plus an 8-bit colour.
    localparam int CELL_W       = 5;
    localparam int RECT_X0_LSB  = 23;
    localparam int RECT_Y0_LSB  = 18;
    localparam int RECT_X1_LSB  = 13;
    localparam int RECT_Y1_LSB  = 8;
    localparam int RECT_COL_LSB = 0;

    // LINE/CHAR words: physical coordinate, colour and pair marker bit.
    localparam int X_W          = 10;
    localparam int Y_W          = 9;
    localparam int COLOR_W      = 8;
    localparam int LINE_X_LSB   = 18;
    localparam int LINE_Y_LSB   = 9;
    localparam int LINE_COL_LSB = 1;
    localparam int LAST_BIT     = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PAIR,
        ST_RECT,
        ST_LINE,
        ST_CHAR
    } state_t;

endpackage

// File: rtl/snake_cmd_fifo.sv
// First-word-fall-through command FIFO. The head word is visible on rd_data
// whenever empty is low; a read and a write on a full FIFO both succeed.
module snake_cmd_fifo #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage write port.
    // NOTE: the array has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/snake_cmd_exec.sv
// Snake command executor: buffers command words, decodes RECT/LINE/CHAR and
// streams pixel writes or char-draw bundles with valid/ready handshakes.
module snake_cmd_exec #(
    parameter int FIFO_DEPTH = 128,
    parameter int SPIXEL     = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cmd,
    input  logic        cmd_vld,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [7:0]  pix_color,
    output logic        pix_we,
    input  logic        pix_ready,
    output logic [63:0] chr_data,
    output logic        chr_vld,
    input  logic        chr_ready,
    output logic        busy,
    output logic        cmd_ovf,
    output logic        cmd_err
);

    import snake_cmd_pkg::*;

    state_t                 state, state_n;
    logic [CMD_WIDTH-1:0]   fifo_head;
    logic                   fifo_full, fifo_empty;
    logic [CMD_WIDTH-1:0]   cmd_q;      // word under decode
    logic [CMD_WIDTH-1:0]   first_q;    // first word of a LINE/CHAR pair
    logic                   have_first;
    logic [X_W-1:0]         x_lo, x_hi;
    logic [Y_W-1:0]         y_hi;

    // FSM strobes
    logic pop, err_set, ld_rect, ld_line, ld_chr, set_first, clr_first;

    snake_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cmd_vld),
        .wr_data (cmd),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Field extraction from the word under decode and the held first word.
    logic [OP_W-1:0]    op_q, op_first;
    logic               last_q;
    logic [CELL_W-1:0]  rx0, ry0, rx1, ry1;
    logic [COLOR_W-1:0] rect_col, line_col;
    logic [X_W-1:0]     lxa, lxb;
    logic [Y_W-1:0]     lya, lyb;

    assign op_q     = cmd_q[OP_LSB +: OP_W];
    assign op_first = first_q[OP_LSB +: OP_W];
    assign last_q   = cmd_q[LAST_BIT];
    assign rx0      = cmd_q[RECT_X0_LSB +: CELL_W];
    assign ry0      = cmd_q[RECT_Y0_LSB +: CELL_W];
    assign rx1      = cmd_q[RECT_X1_LSB +: CELL_W];
    assign ry1      = cmd_q[RECT_Y1_LSB +: CELL_W];
    assign rect_col = cmd_q[RECT_COL_LSB +: COLOR_W];
    assign line_col = cmd_q[LINE_COL_LSB +: COLOR_W];
    assign lxa      = first_q[LINE_X_LSB +: X_W];
    assign lya      = first_q[LINE_Y_LSB +: Y_W];
    assign lxb      = cmd_q[LINE_X_LSB +: X_W];
    assign lyb      = cmd_q[LINE_Y_LSB +: Y_W];

    logic rect_ok, line_ok, pair_ok;
    assign rect_ok = (rx1 >= rx0) && (ry1 >= ry0);
    assign line_ok = (lya == lyb) || (lxa == lxb);
    assign pair_ok = (op_q == op_first) && last_q;

    // Cell-to-pixel scaling, consumed only on the load cycle of a RECT.
    logic [X_W-1:0] rect_x_lo, rect_x_hi;
    logic [Y_W-1:0] rect_y_lo, rect_y_hi;
    assign rect_x_lo = X_W'(int'(rx0) * SPIXEL);
    assign rect_x_hi = X_W'((int'(rx1) + 1) * SPIXEL - 1);
    assign rect_y_lo = Y_W'(int'(ry0) * SPIXEL);
    assign rect_y_hi = Y_W'((int'(ry1) + 1) * SPIXEL - 1);

    // Bounding box of a line: one axis is degenerate for any valid line.
    logic [X_W-1:0] line_x_lo, line_x_hi;
    logic [Y_W-1:0] line_y_lo, line_y_hi;
    assign line_x_lo = (lxa < lxb) ? lxa : lxb;
    assign line_x_hi = (lxa < lxb) ? lxb : lxa;
    assign line_y_lo = (lya < lyb) ? lya : lyb;
    assign line_y_hi = (lya < lyb) ? lyb : lya;

    logic pix_fire, pix_done;
    assign pix_fire = pix_we && pix_ready;
    assign pix_done = pix_fire && (pix_x == x_hi) && (pix_y == y_hi);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Next-state and control strobes.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        err_set   = 1'b0;
        ld_rect   = 1'b0;
        ld_line   = 1'b0;
        ld_chr    = 1'b0;
        set_first = 1'b0;
        clr_first = 1'b0;
        case (state)
            ST_IDLE, ST_PAIR: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (have_first) begin
                    clr_first = 1'b1;
                    if (!pair_ok) begin
                        // Drop the orphan first word and re-decode this one.
                        err_set = 1'b1;
                        state_n = ST_FETCH;
                    end else if (op_q == OP_CHAR) begin
                        ld_chr  = 1'b1;
                        state_n = ST_CHAR;
                    end else if (line_ok) begin
                        ld_line = 1'b1;
                        state_n = ST_LINE;
                    end else begin
                        err_set = 1'b1;
                        state_n = ST_IDLE;
                    end
                end else begin
                    case (op_q)
                        OP_RECT: begin
                            if (rect_ok) begin
                                ld_rect = 1'b1;
                                state_n = ST_RECT;
                            end else begin
                                err_set = 1'b1;
                                state_n = ST_IDLE;
                            end
                        end
                        OP_LINE, OP_CHAR: begin
                            if (!last_q) begin
                                set_first = 1'b1;
                                state_n   = ST_PAIR;
                            end else begin
                                err_set = 1'b1;
                                state_n = ST_IDLE;
                            end
                        end
                        default: begin
                            err_set = 1'b1;
                            state_n = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_RECT, ST_LINE: begin
                if (pix_done) state_n = ST_IDLE;
            end
            ST_CHAR: begin
                if (chr_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Command latching, pixel walker, char bundle and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q      <= '0;
            first_q    <= '0;
            have_first <= 1'b0;
            x_lo       <= '0;
            x_hi       <= '0;
            y_hi       <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_color  <= '0;
            pix_we     <= 1'b0;
            chr_data   <= '0;
            chr_vld    <= 1'b0;
            busy       <= 1'b0;
            cmd_ovf    <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            busy <= (state != ST_IDLE) || !fifo_empty;

            if (pop) cmd_q <= fifo_head;

            if (set_first) begin
                first_q    <= cmd_q;
                have_first <= 1'b1;
            end else if (clr_first) begin
                have_first <= 1'b0;
            end

            if (err_set) cmd_err <= 1'b1;
            if (cmd_vld && fifo_full && !pop) cmd_ovf <= 1'b1;

            if (ld_rect) begin
                pix_x     <= rect_x_lo;
                pix_y     <= rect_y_lo;
                x_lo      <= rect_x_lo;
                x_hi      <= rect_x_hi;
                y_hi      <= rect_y_hi;
                pix_color <= rect_col;
                pix_we    <= 1'b1;
            end else if (ld_line) begin
                pix_x     <= line_x_lo;
                pix_y     <= line_y_lo;
                x_lo      <= line_x_lo;
                x_hi      <= line_x_hi;
                y_hi      <= line_y_hi;
                pix_color <= line_col;
                pix_we    <= 1'b1;
            end else if (pix_fire) begin
                if (pix_x == x_hi) begin
                    if (pix_y == y_hi) begin
                        pix_we <= 1'b0;
                    end else begin
                        pix_x <= x_lo;
                        pix_y <= pix_y + 1'b1;
                    end
                end else begin
                    pix_x <= pix_x + 1'b1;
                end
            end

            if (ld_chr) begin
                chr_data <= {first_q, cmd_q};
                chr_vld  <= 1'b1;
            end else if (chr_vld && chr_ready) begin
                chr_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_snake_cmd_exec.sv
// Directed, table-driven bench for snake_cmd_exec.
module tb_snake_cmd_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd;
    logic        cmd_vld;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [7:0]  pix_color;
    logic        pix_we;
    logic        pix_ready = 1'b1;
    logic [63:0] chr_data;
    logic        chr_vld;
    logic        chr_ready;
    logic        busy, cmd_ovf, cmd_err;

    // Second instance with a shallow FIFO, used for the overflow case.
    logic [9:0]  p16_x;
    logic [8:0]  p16_y;
    logic [7:0]  p16_color;
    logic        p16_we;
    logic [63:0] c16_data;
    logic        c16_vld, busy16, ovf16, err16;

    snake_cmd_exec #(.FIFO_DEPTH(128), .SPIXEL(20)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_vld(cmd_vld),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .pix_we(pix_we),
        .pix_ready(pix_ready), .chr_data(chr_data), .chr_vld(chr_vld),
        .chr_ready(chr_ready), .busy(busy), .cmd_ovf(cmd_ovf), .cmd_err(cmd_err)
    );

    snake_cmd_exec #(.FIFO_DEPTH(16), .SPIXEL(20)) dut16 (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_vld(cmd_vld),
        .pix_x(p16_x), .pix_y(p16_y), .pix_color(p16_color), .pix_we(p16_we),
        .pix_ready(pix_ready), .chr_data(c16_data), .chr_vld(c16_vld),
        .chr_ready(chr_ready), .busy(busy16), .cmd_ovf(ovf16), .cmd_err(err16)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [7:0] c;
    } pix_t;

    pix_t px_q[$];
    int   xc_q[$];
    int   hold_viol = 0;
    int   chr_xfers = 0;
    bit   rand_mode = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_send_cyc = 0;
    int   busy_low_cyc = 0;

    // Ready generator: always ready, or a coin toss per cycle.
    always @(posedge clk) begin
        #1;
        pix_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Transfer monitor, sampled mid-cycle.
    pix_t prev_pix;
    bit   stall_prev = 0;
    always @(negedge clk) begin
        if (stall_prev && pix_we && ({pix_x, pix_y, pix_color} != prev_pix)) hold_viol++;
        stall_prev = pix_we && !pix_ready;
        prev_pix   = {pix_x, pix_y, pix_color};
        if (pix_we === 1'b1 && pix_ready) begin
            px_q.push_back({pix_x, pix_y, pix_color});
            xc_q.push_back(cyc);
        end
        if (chr_vld === 1'b1 && chr_ready) chr_xfers++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_vld = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        px_q.delete();
        xc_q.delete();
        hold_viol = 0;
        chr_xfers = 0;
    endtask

    task automatic send(input logic [31:0] w);
        cmd = w;
        cmd_vld = 1'b1;
        last_send_cyc = cyc;
        tick();
        cmd_vld = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        tick();
        tick();
        for (int i = 0; i < bound; i++) begin
            if (!busy) break;
            tick();
        end
        busy_low_cyc = cyc;
        check({name, "_idle"}, 64'(busy), 64'd0);
    endtask

    // Compare the captured stream with a row-major walk of the given box.
    task automatic check_pixels(input string name, input int xlo, input int xhi,
                                input int ylo, input int yhi, input int npix,
                                input logic [7:0] col);
        int w, bad;
        w = xhi - xlo + 1;
        bad = 0;
        for (int k = 0; k < px_q.size(); k++) begin
            if (int'(px_q[k].x) != xlo + k % w || int'(px_q[k].y) != ylo + k / w ||
                px_q[k].c != col) bad++;
        end
        check({name, "_count"}, 64'(px_q.size()), 64'(npix));
        check({name, "_seq_bad"}, 64'(bad), 64'd0);
    endtask

    function automatic logic [31:0] rect_w(input int x0, input int y0, input int x1,
                                           input int y1, input logic [7:0] c);
        return {4'h1, 5'(x0), 5'(y0), 5'(x1), 5'(y1), c};
    endfunction

    function automatic logic [31:0] line_w(input int x, input int y, input logic [7:0] c,
                                           input logic last);
        return {4'h9, 10'(x), 9'(y), c, last};
    endfunction

    typedef struct {
        logic [31:0] w0, w1;
        int          nw;
        int          xlo, xhi, ylo, yhi, npix;
        logic [7:0]  col;
        int          err;
        int          lat;   // cycles from last word sent to first pixel; 0 = not checked
    } vec_t;

    vec_t vt[11];

    initial begin
        logic [31:0] cw0, cw1;
        int          bad, n_after, gap;

        vt[0]  = '{rect_w(0, 0, 0, 0, 8'h11), 32'h0, 1, 0, 19, 0, 19, 400, 8'h11, 0, 3};
        vt[1]  = '{rect_w(2, 1, 3, 1, 8'ha5), 32'h0, 1, 40, 79, 20, 39, 800, 8'ha5, 0, 3};
        vt[2]  = '{rect_w(3, 0, 2, 0, 8'h01), 32'h0, 1, 0, 0, 0, 0, 0, 8'h01, 1, 0};
        vt[3]  = '{rect_w(0, 2, 0, 1, 8'h01), 32'h0, 1, 0, 0, 0, 0, 0, 8'h01, 1, 0};
        vt[4]  = '{line_w(350, 362, 8'h3c, 1'b0), line_w(290, 362, 8'h3c, 1'b1), 2,
                   290, 350, 362, 362, 61, 8'h3c, 0, 4};
        vt[5]  = '{line_w(100, 10, 8'h07, 1'b0), line_w(100, 5, 8'he1, 1'b1), 2,
                   100, 100, 5, 10, 6, 8'he1, 0, 4};
        vt[6]  = '{line_w(1, 2, 8'h07, 1'b0), line_w(3, 4, 8'h07, 1'b1), 2,
                   0, 0, 0, 0, 0, 8'h07, 1, 0};
        vt[7]  = '{32'h3000_0000, 32'h0, 1, 0, 0, 0, 0, 0, 8'h00, 1, 0};
        vt[8]  = '{line_w(5, 5, 8'h66, 1'b0), rect_w(0, 0, 0, 0, 8'h11), 2,
                   0, 19, 0, 19, 400, 8'h11, 1, 0};
        vt[9]  = '{line_w(7, 9, 8'h44, 1'b0), line_w(7, 9, 8'h55, 1'b1), 2,
                   7, 7, 9, 9, 1, 8'h55, 0, 4};
        vt[10] = '{rect_w(31, 23, 31, 23, 8'hff), 32'h0, 1, 620, 639, 460, 479, 400, 8'hff, 0, 3};

        cmd = '0;
        cmd_vld = 1'b0;
        chr_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_pix_we", 64'(pix_we), 64'd0);
        check("rst_chr_vld", 64'(chr_vld), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ovf", 64'(cmd_ovf), 64'd0);
        check("rst_err", 64'(cmd_err), 64'd0);
        check("rst_pix_x", 64'(pix_x), 64'd0);
        check("rst_pix_y", 64'(pix_y), 64'd0);
        check("rst_pix_color", 64'(pix_color), 64'd0);
        check("rst_chr_data", chr_data, 64'd0);
        check("rst_ovf16", 64'(ovf16), 64'd0);
        rst = 1'b0;

        // Table of single commands and pairs
        for (int i = 0; i < 11; i++) begin
            do_reset();
            send(vt[i].w0);
            if (vt[i].nw == 2) send(vt[i].w1);
            wait_idle($sformatf("v%0d", i), 5000);
            check_pixels($sformatf("v%0d", i), vt[i].xlo, vt[i].xhi, vt[i].ylo,
                         vt[i].yhi, vt[i].npix, vt[i].col);
            check($sformatf("v%0d_err", i), 64'(cmd_err), 64'(vt[i].err));
            if (vt[i].lat > 0 && xc_q.size() > 0)
                check($sformatf("v%0d_latency", i), 64'(xc_q[0] - last_send_cyc), 64'(vt[i].lat));
            if (xc_q.size() > 0)
                check($sformatf("v%0d_busy_drop", i),
                      64'(busy_low_cyc - xc_q[xc_q.size()-1]), 64'd2);
        end

        // Back-to-back RECTs: at most two idle cycles between them
        do_reset();
        send(rect_w(0, 0, 0, 0, 8'h11));
        send(rect_w(1, 0, 1, 0, 8'h22));
        wait_idle("b2b", 5000);
        check("b2b_count", 64'(px_q.size()), 64'd800);
        if (px_q.size() > 400) begin
            gap = xc_q[400] - xc_q[399] - 1;
            check("b2b_gap_le2", 64'(gap <= 2), 64'd1);
            check("b2b_second_first", 64'(px_q[400]), 64'({10'd20, 9'd0, 8'h22}));
        end

        // Random pix_ready stalls
        do_reset();
        rand_mode = 1'b1;
        send(rect_w(0, 0, 0, 0, 8'h11));
        wait_idle("rnd", 5000);
        rand_mode = 1'b0;
        check_pixels("rnd", 0, 19, 0, 19, 400, 8'h11);
        check("rnd_hold", 64'(hold_viol), 64'd0);

        // CHAR pair with chr_ready held low for 10 cycles
        do_reset();
        cw0 = {4'ha, 10'd70, 9'd120, 8'h53, 1'b0};
        cw1 = {4'ha, 10'd0, 9'd0, 8'h0f, 1'b1};
        send(cw0);
        send(cw1);
        for (int i = 0; i < 20; i++) begin
            if (chr_vld) break;
            tick();
        end
        check("chr_vld_up", 64'(chr_vld), 64'd1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (chr_vld !== 1'b1 || chr_data !== {cw0, cw1}) bad++;
            tick();
        end
        check("chr_hold_bad", 64'(bad), 64'd0);
        check("chr_data", chr_data, {cw0, cw1});
        chr_ready = 1'b1;
        tick();
        chr_ready = 1'b0;
        tick();
        check("chr_xfers", 64'(chr_xfers), 64'd1);
        check("chr_vld_down", 64'(chr_vld), 64'd0);
        check("chr_no_pix", 64'(px_q.size()), 64'd0);

        // Reset in the middle of a RECT
        do_reset();
        send(rect_w(2, 1, 3, 1, 8'ha5));
        repeat (50) tick();
        check("mid_pix_we_before", 64'(pix_we), 64'd1);
        rst = 1'b1;
        tick();
        check("mid_pix_we_after", 64'(pix_we), 64'd0);
        rst = 1'b0;
        n_after = px_q.size();
        repeat (30) tick();
        check("mid_no_more_pix", 64'(px_q.size()), 64'(n_after));
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_pix_x", 64'(pix_x), 64'd0);

        // Long RECT then 76 back-to-back words: depth 128 absorbs them, depth 16 cannot
        do_reset();
        send(rect_w(0, 0, 3, 3, 8'h77));
        for (int i = 0; i < 76; i++) send({4'h0, 28'(i)});
        wait_idle("ovf", 20000);
        check("ovf_count", 64'(px_q.size()), 64'd6400);
        check("ovf_128", 64'(cmd_ovf), 64'd0);
        check("ovf_16", 64'(ovf16), 64'd1);
        check("ovf_err", 64'(cmd_err), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
